// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - IR/MDR memory access sequencer for the multicycle datapath
// Handles an enable/acknowledge access to a variable-latency memory and aborts it after TIMEOUT cycles.
module mem_port_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              iord,
  input  logic              we,
  input  logic              ir_sel,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              err_q, err_d;
  logic              timeout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    sel_d   = sel_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    timeout = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = iord ? alu_out : pc;
          wdata_d = wdata;
          we_d    = we;
          sel_d   = ir_sel;
          cnt_d   = 8'd0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // An acknowledge on the last allowed cycle still completes the access.
        if (mem_ack) begin
          if (!we_q) begin
            if (sel_q) ir_d  = mem_rdata;
            else       mdr_d = mem_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A fresh timeout beats a simultaneous clear.
    if (timeout)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      ir_q    <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed-vector bench for mem_port_ctrl
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, iord, we, ir_sel, mem_ack, err_clr;
  logic [31:0] pc, alu_out, wdata, mem_rdata;
  logic        mem_en, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, ir, mdr;

  int n_vec = 0;
  int n_err = 0;
  int n_en, n_busy, n_done;

  mem_port_ctrl #(.DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .iord(iord), .we(we), .ir_sel(ir_sel),
    .pc(pc), .alu_out(alu_out), .wdata(wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .ir(ir), .mdr(mdr),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request pulse (or held request), then the memory acks on ACCESS cycle ack_at (0 = never).
  task automatic access(input logic a_iord, input logic a_we, input logic a_sel,
                        input logic [31:0] a_pc, input logic [31:0] a_alu,
                        input logic [31:0] a_wd, input logic [31:0] a_rd,
                        input int ack_at, input logic req_hold, input logic exp_err);
    logic [31:0] exp_addr;
    logic        ended;
    exp_addr = a_iord ? a_alu : a_pc;
    iord = a_iord; we = a_we; ir_sel = a_sel;
    pc = a_pc; alu_out = a_alu; wdata = a_wd;
    req = 1'b1;
    tick();
    if (!req_hold) req = 1'b0;
    // Change the request-time inputs to prove they were latched.
    pc = ~a_pc; alu_out = ~a_alu; wdata = ~a_wd; iord = ~a_iord; we = ~a_we;
    n_en = 0; n_busy = 0; n_done = 0; ended = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      n_busy++;
      if (mem_en) begin
        n_en++;
        check_eq("acc_addr", mem_addr, exp_addr);
        check_eq("acc_we", {31'd0, mem_we}, {31'd0, a_we});
        if (a_we) check_eq("acc_wdata", mem_wdata, a_wd);
        mem_ack   = (n_en == ack_at);
        mem_rdata = (n_en == ack_at) ? a_rd : 32'hBAD0BAD0;
      end else begin
        mem_ack = 1'b0;
        if (done) begin
          n_done++;
          check_eq("done_err", {31'd0, err}, {31'd0, exp_err});
        end
      end
      tick();
    end
    check_eq("acc_ended", {31'd0, ended}, 32'd1);
    mem_ack = 1'b0;
    if (req_hold) begin
      req = 1'b0;
      tick();
      check_eq("held_req_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit, want $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; iord = 1'b0; we = 1'b0; ir_sel = 1'b0;
    mem_ack = 1'b0; err_clr = 1'b0;
    pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_ir", ir, 32'd0);
    check_eq("rst_mdr", mdr, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);

    // Zero-wait instruction fetch
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 32'h8C220004, 1, 1'b0, 1'b0);
    check_eq("fetch_en", n_en, 1);
    check_eq("fetch_busy", n_busy, 2);
    check_eq("fetch_done", n_done, 1);
    check_eq("fetch_ir", ir, 32'h8C220004);
    check_eq("fetch_mdr", mdr, 32'h0);

    // Load with three wait cycles
    access(1'b1, 1'b0, 1'b0, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 4, 1'b0, 1'b0);
    check_eq("load_en", n_en, 4);
    check_eq("load_busy", n_busy, 5);
    check_eq("load_mdr", mdr, 32'hDEADBEEF);
    check_eq("load_ir", ir, 32'h8C220004);

    // Store
    access(1'b1, 1'b1, 1'b1, 32'h48, 32'h200, 32'h12345678, 32'hFFFFFFFF, 2, 1'b0, 1'b0);
    check_eq("store_en", n_en, 2);
    check_eq("store_done", n_done, 1);
    check_eq("store_ir", ir, 32'h8C220004);
    check_eq("store_mdr", mdr, 32'hDEADBEEF);

    // Timeout with no acknowledge
    access(1'b0, 1'b0, 1'b1, 32'h4C, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    check_eq("to_en", n_en, 15);
    check_eq("to_done", n_done, 1);
    check_eq("to_ir", ir, 32'h8C220004);
    check_eq("to_mdr", mdr, 32'hDEADBEEF);
    tick(); tick();
    check_eq("to_err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("to_err_clr", {31'd0, err}, 32'd0);

    // Ack on the final allowed cycle, request held high throughout
    access(1'b1, 1'b0, 1'b1, 32'h50, 32'h300, 32'h0, 32'hCAFEF00D, 15, 1'b1, 1'b0);
    check_eq("last_en", n_en, 15);
    check_eq("last_done", n_done, 1);
    check_eq("last_err", {31'd0, err}, 32'd0);
    check_eq("last_ir", ir, 32'hCAFEF00D);

    // Timeout while err_clr is held: the set wins
    err_clr = 1'b1;
    access(1'b0, 1'b0, 1'b0, 32'h54, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    err_clr = 1'b0;
    check_eq("setclr_en", n_en, 15);
    check_eq("setclr_err_after", {31'd0, err}, 32'd0);

    // Reset in the second ACCESS cycle, then a late ack
    iord = 1'b0; we = 1'b0; ir_sel = 1'b0; pc = 32'h80; req = 1'b1;
    tick();
    req = 1'b0;
    check_eq("pre_rst_en", {31'd0, mem_en}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_en", {31'd0, mem_en}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_ir", ir, 32'd0);
    check_eq("mid_rst_mdr", mdr, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_ack = 1'b0;
    check_eq("late_ack_busy", {31'd0, busy}, 32'd0);
    check_eq("late_ack_done", {31'd0, done}, 32'd0);
    check_eq("late_ack_mdr", mdr, 32'd0);

    access(1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h11112222, 2, 1'b0, 1'b0);
    check_eq("fresh_done", n_done, 1);
    check_eq("fresh_mdr", mdr, 32'h11112222);
    check_eq("fresh_ir", ir, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
